// File: rtl/arb_2to1.sv
// +--------------------------------------------------------------------------+
// | Module   : arb_2to1                                                      |
// | Purpose  : Burst-locked round-robin 2:1 stream arbiter, one output reg.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module arb_2to1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel,
    output logic             en
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOCK_A = 2'd1;
    localparam logic [1:0] c_LOCK_B = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_rr;
    logic             r_granted_once;
    logic             r_sel;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_last;

    logic             w_grant_go;
    logic             w_grant_b;
    logic             w_out_free;
    logic             w_in_acc;
    logic [WIDTH-1:0] w_in_data;
    logic             w_in_last;

    assign w_out_free = !r_y_valid || y_ready;
    assign w_in_acc   = (a_valid && a_ready) || (b_valid && b_ready);
    assign w_in_data  = (r_state == c_LOCK_B) ? b_data : a_data;
    assign w_in_last  = (r_state == c_LOCK_B) ? b_last : a_last;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_go  = 1'b0;
        w_grant_b   = 1'b0;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        case (r_state)
            c_IDLE: begin
                // On a tie the first grant after reset goes to A, then alternates.
                if (a_valid && b_valid) begin
                    w_grant_go = 1'b1;
                    w_grant_b  = r_granted_once ? !r_rr : 1'b0;
                end else if (a_valid) begin
                    w_grant_go = 1'b1;
                    w_grant_b  = 1'b0;
                end else if (b_valid) begin
                    w_grant_go = 1'b1;
                    w_grant_b  = 1'b1;
                end
                if (w_grant_go) begin
                    w_state_nxt = w_grant_b ? c_LOCK_B : c_LOCK_A;
                end
            end
            c_LOCK_A: begin
                a_ready = w_out_free;
                if (a_valid && w_out_free && a_last) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_LOCK_B: begin
                b_ready = w_out_free;
                if (b_valid && w_out_free && b_last) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_rr           <= 1'b0;
            r_granted_once <= 1'b0;
            r_sel          <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_go) begin
                r_rr           <= w_grant_b;
                r_sel          <= w_grant_b;
                r_granted_once <= 1'b1;
            end
        end
    end

    // Single output register: load on input accept, drain on output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_last  <= 1'b0;
        end else if (w_in_acc) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_in_data;
            r_y_last  <= w_in_last;
        end else if (r_y_valid && y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_last  = r_y_last;
    assign sel     = r_sel;
    assign en      = (r_state == c_LOCK_A) || (r_state == c_LOCK_B);

endmodule

`default_nettype wire
